cr_had_dbgreq_arb: RTL and testbench

//  Debug-request arbiter/sequencer in front of the HAD control path. Collects one

---
 rtl/cr_had_dbgreq_arb_if.sv | 33 +++
 rtl/cr_had_dbgreq_arb.sv | 181 ++++++++++++++++++
 tb/tb_cr_had_dbgreq_arb.sv | 322 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cr_had_dbgreq_arb_if.sv
// Debug-request arbiter bus: pad request/ack, synchronous requesters,
// CPU debug-mode handshake and arbiter status.
interface cr_had_dbgreq_arb_if #(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = 2
);
    localparam int S = NUM_REQ + 1;

    logic               pad_had_jdb_req_b;
    logic [NUM_REQ-1:0] src_req;
    logic               iu_yy_xx_dbgon;
    logic               err_clr;
    logic               arb_ctrl_dbg_req;
    logic [ID_W-1:0]    arb_grant_id;
    logic [S-1:0]       arb_src_ack;
    logic               had_pad_jdb_ack_b;
    logic               arb_busy;
    logic               arb_tmo_err;

    // Requester / CPU side
    modport master (
        output pad_had_jdb_req_b, src_req, iu_yy_xx_dbgon, err_clr,
        input  arb_ctrl_dbg_req, arb_grant_id, arb_src_ack,
               had_pad_jdb_ack_b, arb_busy, arb_tmo_err
    );

    // Arbiter side
    modport slave (
        input  pad_had_jdb_req_b, src_req, iu_yy_xx_dbgon, err_clr,
        output arb_ctrl_dbg_req, arb_grant_id, arb_src_ack,
               had_pad_jdb_ack_b, arb_busy, arb_tmo_err
    );
endinterface

// File: rtl/cr_had_dbgreq_arb.sv
// Debug-request arbiter/sequencer in front of HAD control.
// Source 0 is the asynchronous active-low pad request (2-flop synchronised),
// sources 1..NUM_REQ are synchronous level requests. One grant at a time,
// round-robin, followed by the dbgon ack handshake and pad ack pulse.
// Optional feature: define HAD_DBGREQ_TMO_EN to abort a REQ that sees no
// dbgon within TMO_CYC cycles and raise a sticky arb_tmo_err.
module cr_had_dbgreq_arb #(
    parameter int NUM_REQ  = 2,
    parameter int ID_W     = 2,
    parameter int ACK_HOLD = 4,
    parameter int TMO_CYC  = 256
) (
    input  logic                  cpuclk,
    input  logic                  hadrst,
    input  logic                  clk_en,
    cr_had_dbgreq_arb_if.slave    bus
);
    localparam int S      = NUM_REQ + 1;
    localparam int HOLD_W = $clog2(ACK_HOLD);

    typedef enum logic [1:0] {IDLE, REQ, ACK, WAIT_EXIT} state_t;

    state_t              state_q, state_d;
    logic                pad_ff1, pad_ff2;
    logic [S-1:0]        req_vec;
    logic [ID_W-1:0]     rr_grant;
    logic [ID_W-1:0]     ptr_q, ptr_d;
    logic [ID_W-1:0]     grant_q, grant_d;
    logic                ctrl_q, ctrl_d;
    logic [S-1:0]        src_ack_q, src_ack_d;
    logic                ack_b_q, ack_b_d;
    logic                busy_q;
    logic [HOLD_W-1:0]   hold_q, hold_d;

`ifdef HAD_DBGREQ_TMO_EN
    localparam int TMO_W = (TMO_CYC > 1) ? $clog2(TMO_CYC) : 1;
    logic [TMO_W-1:0]    tmo_cnt_q, tmo_cnt_d;
    logic                tmo_set;
    logic                tmo_err_q;
`endif

    // First requesting source at or after ptr, wrapping from S-1 back to 0
    function automatic logic [ID_W-1:0] rr_pick(input logic [S-1:0] req,
                                                input logic [ID_W-1:0] ptr);
        logic [ID_W-1:0] pick;
        logic            found;
        logic [S-1:0]    sh;
        int              idx;
        pick  = '0;
        found = 1'b0;
        for (int k = 0; k < S; k++) begin
            idx = (int'(ptr) + k) % S;
            sh  = req >> idx;
            if (!found && sh[0]) begin
                pick  = ID_W'(idx);
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    assign req_vec  = {bus.src_req, ~pad_ff2};
    assign rr_grant = rr_pick(req_vec, ptr_q);

    // Pad request synchroniser, free-running regardless of clk_en
    always_ff @(posedge cpuclk or posedge hadrst) begin
        if (hadrst) begin
            pad_ff1 <= 1'b1;
            pad_ff2 <= 1'b1;
        end else begin
            pad_ff1 <= bus.pad_had_jdb_req_b;
            pad_ff2 <= pad_ff1;
        end
    end

    // Next-state and next-output logic for the grant/ack sequence
    always_comb begin
        state_d   = state_q;
        ctrl_d    = ctrl_q;
        grant_d   = grant_q;
        src_ack_d = '0;
        ack_b_d   = ack_b_q;
        hold_d    = hold_q;
        ptr_d     = ptr_q;
`ifdef HAD_DBGREQ_TMO_EN
        tmo_cnt_d = tmo_cnt_q;
        tmo_set   = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (!bus.iu_yy_xx_dbgon && (|req_vec)) begin
                    state_d = REQ;
                    ctrl_d  = 1'b1;
                    grant_d = rr_grant;
                    ptr_d   = (rr_grant == ID_W'(S - 1)) ? '0 : rr_grant + 1'b1;
`ifdef HAD_DBGREQ_TMO_EN
                    tmo_cnt_d = '0;
`endif
                end
            end
            REQ: begin
                if (bus.iu_yy_xx_dbgon) begin
                    state_d   = ACK;
                    ctrl_d    = 1'b0;
                    src_ack_d = S'(1) << grant_q;
                    ack_b_d   = (grant_q != '0);
                    hold_d    = HOLD_W'(ACK_HOLD - 1);
                end
`ifdef HAD_DBGREQ_TMO_EN
                else if (tmo_cnt_q == TMO_W'(TMO_CYC - 1)) begin
                    state_d = IDLE;
                    ctrl_d  = 1'b0;
                    tmo_set = 1'b1;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 1'b1;
                end
`endif
            end
            ACK: begin
                if (hold_q == '0) begin
                    state_d = WAIT_EXIT;
                    ack_b_d = 1'b1;
                end else begin
                    hold_d = hold_q - 1'b1;
                end
            end
            WAIT_EXIT: begin
                if (!bus.iu_yy_xx_dbgon) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State, pointer, counters and registered outputs; all hold when clk_en=0
    always_ff @(posedge cpuclk or posedge hadrst) begin
        if (hadrst) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            grant_q   <= '0;
            ctrl_q    <= 1'b0;
            src_ack_q <= '0;
            ack_b_q   <= 1'b1;
            busy_q    <= 1'b0;
            hold_q    <= '0;
        end else if (clk_en) begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            grant_q   <= grant_d;
            ctrl_q    <= ctrl_d;
            src_ack_q <= src_ack_d;
            ack_b_q   <= ack_b_d;
            busy_q    <= (state_d != IDLE);
            hold_q    <= hold_d;
        end
    end

`ifdef HAD_DBGREQ_TMO_EN
    // REQ timeout counter and sticky error; a new timeout beats err_clr
    always_ff @(posedge cpuclk or posedge hadrst) begin
        if (hadrst) begin
            tmo_cnt_q <= '0;
            tmo_err_q <= 1'b0;
        end else if (clk_en) begin
            tmo_cnt_q <= tmo_cnt_d;
            if (tmo_set)          tmo_err_q <= 1'b1;
            else if (bus.err_clr) tmo_err_q <= 1'b0;
        end
    end
    assign bus.arb_tmo_err = tmo_err_q;
`else
    logic unused_err_clr;
    assign unused_err_clr  = bus.err_clr;
    assign bus.arb_tmo_err = 1'b0;
`endif

    assign bus.arb_ctrl_dbg_req  = ctrl_q;
    assign bus.arb_grant_id      = grant_q;
    assign bus.arb_src_ack       = src_ack_q;
    assign bus.had_pad_jdb_ack_b = ack_b_q;
    assign bus.arb_busy          = busy_q;
endmodule

// File: tb/tb_cr_had_dbgreq_arb.sv
// Testbench for cr_had_dbgreq_arb: vector table, directed corner sequences
// and a randomized run against a behavioural model.
module tb_cr_had_dbgreq_arb;
    localparam int NUM_REQ  = 2;
    localparam int ID_W     = 2;
    localparam int ACK_HOLD = 4;
    localparam int S        = NUM_REQ + 1;
`ifdef HAD_DBGREQ_TMO_EN
    localparam int TMO_CYC  = 8;
    localparam bit TMO_ON   = 1'b1;
`else
    localparam int TMO_CYC  = 256;
    localparam bit TMO_ON   = 1'b0;
`endif

    logic cpuclk = 1'b0;
    logic hadrst = 1'b0;
    logic clk_en = 1'b1;
    int   n_chk  = 0;
    int   n_pass = 0;

    cr_had_dbgreq_arb_if #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) bus ();

    cr_had_dbgreq_arb #(
        .NUM_REQ(NUM_REQ), .ID_W(ID_W), .ACK_HOLD(ACK_HOLD), .TMO_CYC(TMO_CYC)
    ) dut (
        .cpuclk(cpuclk),
        .hadrst(hadrst),
        .clk_en(clk_en),
        .bus(bus)
    );

    always #5 cpuclk = ~cpuclk;

    // Output bundle: {ctrl_req, grant_id, src_ack, pad_ack_b, busy, tmo_err}
    localparam logic [8:0] RST_OUTS = 9'b0_00_000_1_0_0;

    typedef struct {
        logic [1:0] src_req;
        logic       dbgon;
        logic       en;
        logic [8:0] exp;
    } vec_t;

    vec_t tbl [12];

    // Behavioural model state
    logic       m_p1, m_p2, m_ctrl, m_wait, m_err;
    logic [1:0] m_grant;
    logic [2:0] m_srcack;
    int         m_ptr, m_ack_left, m_age;

    function automatic logic [8:0] outs();
        return {bus.arb_ctrl_dbg_req, bus.arb_grant_id, bus.arb_src_ack,
                bus.had_pad_jdb_ack_b, bus.arb_busy, bus.arb_tmo_err};
    endfunction

    function automatic logic [8:0] mk(input logic c, input logic [1:0] g,
                                      input logic [2:0] a, input logic ab, input logic b);
        return {c, g, a, ab, b, 1'b0};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic step();
        @(posedge cpuclk);
        #1;
    endtask

    task automatic do_reset();
        hadrst = 1'b1;
        bus.pad_had_jdb_req_b = 1'b1;
        bus.src_req = '0;
        bus.iu_yy_xx_dbgon = 1'b0;
        bus.err_clr = 1'b0;
        clk_en = 1'b1;
        @(posedge cpuclk);
        #1;
        hadrst = 1'b0;
    endtask

    // Steps until ctrl_req is seen or the budget runs out
    task automatic wait_ctrl(input string name);
        for (int i = 0; i < 20; i++) begin
            if (bus.arb_ctrl_dbg_req) break;
            step();
        end
        check(name, bus.arb_ctrl_dbg_req, 1);
    endtask

    task automatic model_reset();
        m_p1 = 1; m_p2 = 1; m_ctrl = 0; m_wait = 0; m_err = 0;
        m_grant = 0; m_srcack = 0; m_ptr = 0; m_ack_left = 0; m_age = 0;
    endtask

    // One enabled-or-not clock edge of the arbiter, from the rules in words:
    // a pending request waits for dbgon, the ack lasts ACK_HOLD cycles,
    // then the arbiter waits for dbgon to drop before granting again.
    task automatic model_edge();
        logic [2:0] reqs;
        logic       set;
        int         s;
        reqs = {bus.src_req, ~m_p2};
        set  = 0;
        if (clk_en) begin
            m_srcack = 0;
            if (m_ctrl) begin
                if (bus.iu_yy_xx_dbgon) begin
                    m_ctrl = 0;
                    m_ack_left = ACK_HOLD;
                    m_srcack = 3'(1 << m_grant);
                end else if (TMO_ON) begin
                    m_age++;
                    if (m_age == TMO_CYC) begin
                        m_ctrl = 0;
                        m_err = 1;
                        set = 1;
                    end
                end
            end else if (m_ack_left > 0) begin
                m_ack_left--;
                if (m_ack_left == 0) m_wait = 1;
            end else if (m_wait) begin
                if (!bus.iu_yy_xx_dbgon) m_wait = 0;
            end else if (!bus.iu_yy_xx_dbgon) begin
                for (int k = 0; k < S; k++) begin
                    s = (m_ptr + k) % S;
                    if (reqs[s]) begin
                        m_grant = 2'(s);
                        m_ctrl = 1;
                        m_ptr = (s + 1) % S;
                        m_age = 0;
                        break;
                    end
                end
            end
            if (TMO_ON && bus.err_clr && !set) m_err = 0;
        end
        m_p2 = m_p1;
        m_p1 = bus.pad_had_jdb_req_b;
    endtask

    function automatic logic [8:0] model_outs();
        logic ab, b;
        ab = !(m_ack_left > 0 && m_grant == 0);
        b  = m_ctrl || (m_ack_left > 0) || m_wait;
        return {m_ctrl, m_grant, m_srcack, ab, b, m_err};
    endfunction

    initial begin
        int lat, low_cnt, ack_cnt, cyc;

        // Vector table: starting from IDLE, pointer 0, pad inactive
        tbl[0]  = '{2'b01, 1'b0, 1'b1, mk(1, 1, 3'b000, 1, 1)};
        tbl[1]  = '{2'b00, 1'b0, 1'b1, mk(1, 1, 3'b000, 1, 1)};
        tbl[2]  = '{2'b00, 1'b1, 1'b1, mk(0, 1, 3'b010, 1, 1)};
        tbl[3]  = '{2'b00, 1'b0, 1'b1, mk(0, 1, 3'b000, 1, 1)};
        tbl[4]  = '{2'b00, 1'b0, 1'b1, mk(0, 1, 3'b000, 1, 1)};
        tbl[5]  = '{2'b00, 1'b0, 1'b1, mk(0, 1, 3'b000, 1, 1)};
        tbl[6]  = '{2'b00, 1'b0, 1'b1, mk(0, 1, 3'b000, 1, 1)};
        tbl[7]  = '{2'b00, 1'b0, 1'b1, mk(0, 1, 3'b000, 1, 0)};
        tbl[8]  = '{2'b11, 1'b0, 1'b0, mk(0, 1, 3'b000, 1, 0)};
        tbl[9]  = '{2'b11, 1'b0, 1'b1, mk(1, 2, 3'b000, 1, 1)};
        tbl[10] = '{2'b11, 1'b1, 1'b0, mk(1, 2, 3'b000, 1, 1)};
        tbl[11] = '{2'b11, 1'b1, 1'b1, mk(0, 2, 3'b100, 1, 1)};

        bus.pad_had_jdb_req_b = 1'b1;
        bus.src_req = '0;
        bus.iu_yy_xx_dbgon = 1'b0;
        bus.err_clr = 1'b0;
        #2;
        hadrst = 1'b1;
        #1;
        check("reset_outs", 32'(outs()), 32'(RST_OUTS));
        @(posedge cpuclk);
        #1;
        hadrst = 1'b0;

        for (int i = 0; i < 12; i++) begin
            bus.src_req = tbl[i].src_req;
            bus.iu_yy_xx_dbgon = tbl[i].dbgon;
            clk_en = tbl[i].en;
            step();
            check($sformatf("vec%0d", i), 32'(outs()), 32'(tbl[i].exp));
        end

        // Pad latency and ack widths
        do_reset();
        bus.pad_had_jdb_req_b = 1'b0;
        lat = 0;
        for (int e = 1; e <= 10; e++) begin
            step();
            if (bus.arb_ctrl_dbg_req) begin
                lat = e;
                break;
            end
        end
        check("pad_latency", lat, 3);
        check("pad_grant_id", bus.arb_grant_id, 0);
        for (int i = 0; i < 4; i++) step();
        check("req_held", bus.arb_ctrl_dbg_req, 1);
        bus.iu_yy_xx_dbgon = 1'b1;
        bus.pad_had_jdb_req_b = 1'b1;
        low_cnt = 0;
        ack_cnt = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (!bus.had_pad_jdb_ack_b) low_cnt++;
            if (bus.arb_src_ack == 3'b001) ack_cnt++;
        end
        check("pad_ack_width", low_cnt, ACK_HOLD);
        check("src_ack_pulse", ack_cnt, 1);
        check("wait_exit_busy", bus.arb_busy, 1);
        bus.iu_yy_xx_dbgon = 1'b0;
        step();
        check("exit_idle", bus.arb_busy, 0);

        // Reset in the middle of a pad ack
        bus.pad_had_jdb_req_b = 1'b0;
        wait_ctrl("wait_pad_grant");
        check("pad_grant_wrap", bus.arb_grant_id, 0);
        bus.iu_yy_xx_dbgon = 1'b1;
        bus.pad_had_jdb_req_b = 1'b1;
        step();
        step();
        check("mid_ack_low", bus.had_pad_jdb_ack_b, 0);
        hadrst = 1'b1;
        #1;
        check("mid_ack_reset", 32'(outs()), 32'(RST_OUTS));
        bus.pad_had_jdb_req_b = 1'b0;
        bus.iu_yy_xx_dbgon = 1'b0;
        bus.src_req = '0;
        step();
        hadrst = 1'b0;
        step();
        step();
        bus.src_req = 2'b01;
        step();
        check("ptr_after_reset", 32'(outs()), 32'(mk(1, 0, 3'b000, 1, 1)));

        // Round-robin with all sources held
        do_reset();
        bus.pad_had_jdb_req_b = 1'b0;
        step();
        step();
        bus.src_req = 2'b11;
        for (int g = 0; g < 4; g++) begin
            wait_ctrl($sformatf("rr_wait%0d", g));
            check($sformatf("rr_order%0d", g), bus.arb_grant_id, g % 3);
            bus.iu_yy_xx_dbgon = 1'b1;
            for (int i = 0; i < ACK_HOLD + 2; i++) step();
            bus.iu_yy_xx_dbgon = 1'b0;
            step();
        end

        // Requests ignored while dbgon is high in IDLE
        do_reset();
        bus.iu_yy_xx_dbgon = 1'b1;
        bus.src_req = 2'b11;
        for (int i = 0; i < 5; i++) begin
            step();
            check($sformatf("dbgon_block%0d", i), {bus.arb_ctrl_dbg_req, bus.arb_busy}, 0);
        end
        bus.iu_yy_xx_dbgon = 1'b0;
        step();
        check("grant_after_dbgon", 32'(outs()), 32'(mk(1, 1, 3'b000, 1, 1)));

`ifdef HAD_DBGREQ_TMO_EN
        // Timeout abort and sticky error
        do_reset();
        bus.src_req = 2'b01;
        step();
        check("tmo_req", bus.arb_ctrl_dbg_req, 1);
        bus.src_req = 2'b00;
        cyc = 0;
        for (int i = 1; i <= 20; i++) begin
            step();
            if (!bus.arb_ctrl_dbg_req) begin
                cyc = i;
                break;
            end
        end
        check("tmo_cycles", cyc, TMO_CYC);
        check("tmo_err_set", {bus.arb_tmo_err, bus.arb_busy, bus.arb_src_ack}, 5'b10000);
        step();
        check("tmo_err_sticky", bus.arb_tmo_err, 1);
        bus.err_clr = 1'b1;
        step();
        bus.err_clr = 1'b0;
        check("tmo_err_clr", bus.arb_tmo_err, 0);
`else
        cyc = 0;
`endif

        // Randomized run against the behavioural model
        do_reset();
        model_reset();
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 7) == 0) bus.pad_had_jdb_req_b = ~bus.pad_had_jdb_req_b;
            if ($urandom_range(0, 3) == 0) bus.src_req = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0) bus.iu_yy_xx_dbgon = ~bus.iu_yy_xx_dbgon;
            clk_en = ($urandom_range(0, 7) != 0);
            bus.err_clr = ($urandom_range(0, 15) == 0);
            model_edge();
            step();
            check($sformatf("rand%0d", n), 32'(outs()), 32'(model_outs()));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_chk);
        $fatal(1);
    end
endmodule
